// File: rtl/reg_dump.sv
// reg_dump: walks register-file indices 0..NUM_REGS-1 and presents each
//   value as one valid/ready word. Each word takes a FETCH cycle and then
//   a SEND cycle, so the best-case rate is one word per 2 cycles.
// Backpressure: a word stays in SEND with stable addr/data until accepted.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, abort       begin a dump (sampled in IDLE only) / cancel a dump
//   rd_addr, rd_data   combinational register-file read port
//   out_valid/out_ready/out_addr/out_data  dumped word handshake
//   busy, done         not IDLE / one-cycle pulse after the last accept
module reg_dump #(
  parameter int REGF_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [4:0]            rd_addr,
  input  logic [REGF_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            out_addr,
  output logic [REGF_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_SEND   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t                r_state,     w_state_nxt;
  logic [4:0]            r_idx,       w_idx_nxt;
  logic                  r_out_valid, w_out_valid_nxt;
  logic [4:0]            r_out_addr,  w_out_addr_nxt;
  logic [REGF_WIDTH-1:0] r_out_data,  w_out_data_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_addr  <= w_out_addr_nxt;
      r_out_data  <= w_out_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_out_valid_nxt = r_out_valid;
    w_out_addr_nxt  = r_out_addr;
    w_out_data_nxt  = r_out_data;
    // Abort outranks everything outside IDLE, including a handshake in the
    // same cycle; it also prevents FINISH from ever being entered.
    if ((r_state != S_IDLE) && abort) begin
      w_state_nxt     = S_IDLE;
      w_idx_nxt       = '0;
      w_out_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // abort in IDLE has no effect of its own but masks start
          if (start && !abort) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_FETCH;
          end
        end
        S_FETCH: begin
          w_out_data_nxt  = rd_data;
          w_out_addr_nxt  = r_idx;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_SEND;
        end
        S_SEND: begin
          if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
            if (r_idx == LAST_IDX) begin
              w_state_nxt = S_FINISH;
            end else begin
              w_idx_nxt   = r_idx + 5'd1;
              w_state_nxt = S_FETCH;
            end
          end
        end
        S_FINISH: begin
          // index returns to 0 so rd_addr reads 0 while idle
          w_idx_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_idx_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign rd_addr   = r_idx;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FINISH);

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: directed bench for reg_dump (32-register and 4-register builds).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_reg_dump;

  logic        clk;
  logic        rst_n;
  logic        start, abort, out_ready;
  logic [4:0]  rd_addr, out_addr;
  logic [31:0] rd_data, out_data;
  logic        out_valid, busy, done;

  logic        start4, abort4, out_ready4;
  logic [4:0]  rd_addr4, out_addr4;
  logic [31:0] rd_data4, out_data4;
  logic        out_valid4, busy4, done4;

  int n_cmp = 0;
  int n_err = 0;

  // register-file models: reg[i] = i*0x11111111 and a distinct small-build pattern
  assign rd_data  = 32'(rd_addr) * 32'h1111_1111;
  assign rd_data4 = {27'h0, rd_addr4} ^ 32'hCAFE_0000;

  reg_dump #(.REGF_WIDTH(32), .NUM_REGS(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  reg_dump #(.REGF_WIDTH(32), .NUM_REGS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .rd_addr(rd_addr4), .rd_data(rd_data4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_addr(out_addr4), .out_data(out_data4),
    .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if ({out_valid, busy, done} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got v/b/d=%b want 000", {out_valid, busy, done}); end
    n_cmp++; if (rd_addr !== 5'd0 || out_addr !== 5'd0) begin n_err++; $display("FAIL reset_addr: got rd=%0d out=%0d want 0/0", rd_addr, out_addr); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_cmp++; if ({out_valid4, busy4, done4, out_addr4} !== 8'h00) begin n_err++; $display("FAIL reset_dut4: got %b want 0", {out_valid4, busy4, done4, out_addr4}); end
    tick();
    rst_n = 1'b1;
  endtask

  // start on the first edge after reset release, then stream all 32 words
  task automatic test_full_dump();
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if ({busy, out_valid, done} !== 3'b100) begin n_err++; $display("FAIL full_fetch0: got b/v/d=%b want 100", {busy, out_valid, done}); end
    for (int i = 0; i < 32; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_addr !== 5'(i)) begin n_err++; $display("FAIL full_word[%0d]: got v=%b addr=%0d want v=1 addr=%0d", i, out_valid, out_addr, i); end
      n_cmp++; if (out_data !== 32'(i) * 32'h1111_1111) begin n_err++; $display("FAIL full_data[%0d]: got %h want %h", i, out_data, 32'(i) * 32'h1111_1111); end
      tick();
      n_cmp++; if (out_valid !== 1'b0 || done !== (i == 31) || busy !== 1'b1) begin n_err++; $display("FAIL full_gap[%0d]: got v/d/b=%b%b%b want 0%b1", i, out_valid, done, busy, (i == 31)); end
    end
    tick();
    n_cmp++; if ({done, busy} !== 2'b00 || rd_addr !== 5'd0) begin n_err++; $display("FAIL full_end: got d/b=%b%b rd=%0d want 00/0", done, busy, rd_addr); end
  endtask

  // stall word 7 for 5 cycles, then drain the remainder
  task automatic test_backpressure();
    int e, dn, cnt;
    bit fin;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      tick();
      if (out_valid && out_addr == 5'd7) fin = 1;
    end
    n_cmp++; if (fin !== 1'b1) begin n_err++; $display("FAIL bp_reach7: got %b want 1", fin); end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_addr !== 5'd7 || out_data !== 32'h7777_7777) begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b addr=%0d data=%h want 1/7/77777777", k, out_valid, out_addr, out_data); end
    end
    out_ready = 1'b1;
    e = 7; dn = 0; cnt = 0; fin = 0;
    for (int c = 0; c < 100 && !fin; c++) begin
      if (out_valid) begin
        n_cmp++; if (out_addr !== 5'(e) || out_data !== 32'(e) * 32'h1111_1111) begin n_err++; $display("FAIL bp_seq: got addr=%0d data=%h want %0d", out_addr, out_data, e); end
        e++; cnt++;
      end
      if (done) begin dn++; fin = 1; end
      tick();
    end
    n_cmp++; if (cnt !== 25 || dn !== 1) begin n_err++; $display("FAIL bp_count: got words=%0d done=%0d want 25/1", cnt, dn); end
  endtask

  // start pulsed while word 10 is presented must be ignored
  task automatic test_start_ignored();
    int e, dn;
    bit fin;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    e = 0; dn = 0; fin = 0;
    for (int c = 0; c < 100 && !fin; c++) begin
      tick();
      start = 1'b0;
      if (out_valid) begin
        n_cmp++; if (out_addr !== 5'(e)) begin n_err++; $display("FAIL ign_seq: got addr=%0d want %0d", out_addr, e); end
        if (e == 10) start = 1'b1;
        e++;
      end
      if (done) begin dn++; fin = 1; end
    end
    tick();
    tick();
    n_cmp++; if (e !== 32 || dn !== 1) begin n_err++; $display("FAIL ign_count: got words=%0d done=%0d want 32/1", e, dn); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL ign_idle: got b/d=%b%b want 00", busy, done); end
  endtask

  task automatic test_abort();
    bit fin;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      tick();
      if (out_valid && out_addr == 5'd12) fin = 1;
    end
    n_cmp++; if (fin !== 1'b1) begin n_err++; $display("FAIL ab_reach12: got %b want 1", fin); end
    abort = 1'b1;   // concurrent with the handshake of word 12
    tick();
    abort = 1'b0;
    n_cmp++; if ({busy, out_valid, done} !== 3'b000 || rd_addr !== 5'd0) begin n_err++; $display("FAIL ab_idle: got b/v/d=%b rd=%0d want 000/0", {busy, out_valid, done}, rd_addr); end
    tick();
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL ab_nodone: got b/d=%b%b want 00", busy, done); end
    start = 1'b1;
    abort = 1'b1;   // abort in IDLE masks start
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ab_idle_prio: got busy=%b want 0", busy); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_addr !== 5'd0 || out_data !== 32'h0) begin n_err++; $display("FAIL ab_restart: got v=%b addr=%0d data=%h want 1/0/0", out_valid, out_addr, out_data); end
    tick();
    abort = 1'b1;   // abort while in FETCH of word 1
    tick();
    abort = 1'b0;
    n_cmp++; if ({busy, out_valid, done} !== 3'b000 || rd_addr !== 5'd0) begin n_err++; $display("FAIL ab_fetch: got b/v/d=%b rd=%0d want 000/0", {busy, out_valid, done}, rd_addr); end
  endtask

  task automatic test_async_reset();
    bit fin;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    fin = 0;
    for (int c = 0; c < 20 && !fin; c++) begin
      tick();
      if (out_valid && out_addr == 5'd3) fin = 1;
    end
    out_ready = 1'b0;
    n_cmp++; if (fin !== 1'b1 || out_data !== 32'h3333_3333) begin n_err++; $display("FAIL rst_pre: got fin=%b data=%h want 1/33333333", fin, out_data); end
    #2;
    rst_n = 1'b0;   // between edges
    #1;
    n_cmp++; if ({out_valid, busy, done} !== 3'b000 || out_addr !== 5'd0 || rd_addr !== 5'd0 || out_data !== 32'h0) begin n_err++; $display("FAIL rst_async: got v/b/d=%b addr=%0d rd=%0d data=%h want all 0", {out_valid, busy, done}, out_addr, rd_addr, out_data); end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    fin = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done || busy) fin = 1;
    end
    n_cmp++; if (fin !== 1'b0) begin n_err++; $display("FAIL rst_nodone: got activity=%b want 0", fin); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_restart: got busy=%b want 1", busy); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_num_regs4();
    out_ready4 = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (out_valid4 !== 1'b1 || out_addr4 !== 5'(i) || out_data4 !== (32'(i) ^ 32'hCAFE_0000)) begin n_err++; $display("FAIL n4_word[%0d]: got v=%b addr=%0d data=%h", i, out_valid4, out_addr4, out_data4); end
      tick();
      n_cmp++; if (out_valid4 !== 1'b0 || done4 !== (i == 3)) begin n_err++; $display("FAIL n4_gap[%0d]: got v/d=%b%b want 0%b", i, out_valid4, done4, (i == 3)); end
    end
    tick();
    n_cmp++; if ({busy4, done4, out_valid4} !== 3'b000) begin n_err++; $display("FAIL n4_end: got b/d/v=%b want 000", {busy4, done4, out_valid4}); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start4 = 1'b0; abort4 = 1'b0; out_ready4 = 1'b0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_start_ignored();
    test_abort();
    test_async_reset();
    test_num_regs4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
